// File: rtl/julia_pkg.sv
// ---------------------------------------------------------------------------
// julia_pkg
// Shared constants and types for the Julia pixel sequencer slice.
//   WIDTH / FRACTIONAL / INTEGRAL : Q10.10 fixed-point word layout
//   TAG_W                         : opaque pixel tag width
//   ESCAPE_THRESH                 : |z|^2 escape threshold (4.0 in Q10.10)
//   seq_state_t                   : sequencer FSM states
// ---------------------------------------------------------------------------
package julia_pkg;
   localparam int FRACTIONAL = 10;
   localparam int INTEGRAL   = 10;
   localparam int WIDTH      = FRACTIONAL + INTEGRAL;
   localparam int TAG_W      = 16;

   localparam logic signed [WIDTH-1:0] ESCAPE_THRESH = WIDTH'(4 << FRACTIONAL);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } seq_state_t;
endpackage

// File: rtl/julia_pixel_sequencer_if.sv
// ---------------------------------------------------------------------------
// julia_pixel_sequencer_if
// Job and result handshake bundle for julia_pixel_sequencer.
//   Job side    : pixel_valid/pixel_ready, z0_real_in, z0_imag_in,
//                 c_real_in, c_imag_in, cfg_max_iter, pixel_tag_in
//   Result side : result_valid/result_ready, result_iter, result_escaped,
//                 result_tag
// Modports:
//   master : job source and result sink (coordinate generator / colour mapper)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface julia_pixel_sequencer_if
   import julia_pkg::*;
#(
   parameter int WIDTH = julia_pkg::WIDTH,
   parameter int TAG_W = julia_pkg::TAG_W
);
   logic                    pixel_valid;
   logic                    pixel_ready;
   logic signed [WIDTH-1:0] z0_real_in;
   logic signed [WIDTH-1:0] z0_imag_in;
   logic signed [WIDTH-1:0] c_real_in;
   logic signed [WIDTH-1:0] c_imag_in;
   logic [7:0]              cfg_max_iter;
   logic [TAG_W-1:0]        pixel_tag_in;

   logic                    result_valid;
   logic                    result_ready;
   logic [7:0]              result_iter;
   logic                    result_escaped;
   logic [TAG_W-1:0]        result_tag;

   modport master (
      output pixel_valid, z0_real_in, z0_imag_in, c_real_in, c_imag_in,
             cfg_max_iter, pixel_tag_in, result_ready,
      input  pixel_ready, result_valid, result_iter, result_escaped, result_tag
   );

   modport slave (
      input  pixel_valid, z0_real_in, z0_imag_in, c_real_in, c_imag_in,
             cfg_max_iter, pixel_tag_in, result_ready,
      output pixel_ready, result_valid, result_iter, result_escaped, result_tag
   );
endinterface

// File: rtl/z_calculator.sv
// ---------------------------------------------------------------------------
// z_calculator
// Combinational Julia datapath: z_out = z^2 + c, plus |z_out|^2.
// All values signed fixed point with FRACTIONAL fraction bits; products are
// formed at double width, arithmetic-shifted back and truncated to WIDTH,
// so out-of-range results wrap.
//   z_real_in/z_imag_in   : current z
//   c_real_in/c_imag_in   : constant c
//   iteration_in          : pass-through counter input
//   z_real_out/z_imag_out : next z
//   size_squared_out      : |z_out|^2 (may wrap negative on overflow)
//   iteration_out         : iteration_in + 1
// ---------------------------------------------------------------------------
module z_calculator
   import julia_pkg::*;
#(
   parameter int WIDTH      = julia_pkg::WIDTH,
   parameter int FRACTIONAL = julia_pkg::FRACTIONAL
) (
   input  logic signed [WIDTH-1:0] z_real_in,
   input  logic signed [WIDTH-1:0] z_imag_in,
   input  logic signed [WIDTH-1:0] c_real_in,
   input  logic signed [WIDTH-1:0] c_imag_in,
   input  logic [7:0]              iteration_in,
   output logic signed [WIDTH-1:0] z_real_out,
   output logic signed [WIDTH-1:0] z_imag_out,
   output logic signed [WIDTH-1:0] size_squared_out,
   output logic [7:0]              iteration_out
);
   localparam int W2 = 2 * WIDTH;

   logic signed [W2-1:0] zr_x, zi_x, nr_x, ni_x;
   logic signed [W2-1:0] rr, ii, ri, nrr, nii;
   logic signed [W2-1:0] re_full, im_full, sz_full;

   assign zr_x = W2'(z_real_in);
   assign zi_x = W2'(z_imag_in);

   assign rr = zr_x * zr_x;
   assign ii = zi_x * zi_x;
   assign ri = zr_x * zi_x;

   assign re_full = (rr - ii) >>> FRACTIONAL;
   assign im_full = (ri <<< 1) >>> FRACTIONAL;

   assign z_real_out = re_full[WIDTH-1:0] + c_real_in;
   assign z_imag_out = im_full[WIDTH-1:0] + c_imag_in;

   assign nr_x    = W2'(z_real_out);
   assign ni_x    = W2'(z_imag_out);
   assign nrr     = nr_x * nr_x;
   assign nii     = ni_x * ni_x;
   assign sz_full = (nrr + nii) >>> FRACTIONAL;

   assign size_squared_out = sz_full[WIDTH-1:0];
   assign iteration_out    = iteration_in + 8'd1;
endmodule

// File: rtl/julia_pixel_sequencer.sv
// ---------------------------------------------------------------------------
// julia_pixel_sequencer
// Per-pixel iteration controller around z_calculator. Accepts one job,
// iterates z <- z^2 + c once per clock until |z|^2 exceeds 4.0 (or wraps
// negative) or the budget is spent, then presents the iteration count.
//   clk, rst : clock, synchronous active-high reset
//   bus      : julia_pixel_sequencer_if.slave (job in, result out)
//   abort    : only with JULIA_ABORT_EN defined; drops the job in ITER/DONE
// Optional feature macro: JULIA_ABORT_EN
// ---------------------------------------------------------------------------
module julia_pixel_sequencer
   import julia_pkg::*;
#(
   parameter int WIDTH      = julia_pkg::WIDTH,
   parameter int FRACTIONAL = julia_pkg::FRACTIONAL,
   parameter int TAG_W      = julia_pkg::TAG_W
) (
   input  logic clk,
   input  logic rst,
`ifdef JULIA_ABORT_EN
   input  logic abort,
`endif
   julia_pixel_sequencer_if.slave bus
);
   seq_state_t              state_q;
   logic signed [WIDTH-1:0] z_re_q, z_im_q, c_re_q, c_im_q;
   logic [7:0]              budget_q;
   logic [7:0]              iter_q;
   logic                    pixel_ready_q;
   logic                    result_valid_q;
   logic [7:0]              result_iter_q;
   logic                    result_escaped_q;
   logic [TAG_W-1:0]        result_tag_q;

   logic signed [WIDTH-1:0] z_re_d, z_im_d, size_sq_d;
   logic [7:0]              dp_iter_unused;
   logic [7:0]              iter_inc;
   logic                    escape;

   z_calculator #(
      .WIDTH      (WIDTH),
      .FRACTIONAL (FRACTIONAL)
   ) u_zcalc (
      .z_real_in        (z_re_q),
      .z_imag_in        (z_im_q),
      .c_real_in        (c_re_q),
      .c_imag_in        (c_im_q),
      .iteration_in     (iter_q),
      .z_real_out       (z_re_d),
      .z_imag_out       (z_im_d),
      .size_squared_out (size_sq_d),
      .iteration_out    (dp_iter_unused)
   );

   assign iter_inc = iter_q + 8'd1;
   // A negative |z|^2 can only come from wrap-around, so it counts as escape.
   assign escape   = (size_sq_d > ESCAPE_THRESH) || size_sq_d[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         z_re_q           <= '0;
         z_im_q           <= '0;
         c_re_q           <= '0;
         c_im_q           <= '0;
         budget_q         <= '0;
         iter_q           <= '0;
         pixel_ready_q    <= 1'b1;
         result_valid_q   <= 1'b0;
         result_iter_q    <= '0;
         result_escaped_q <= 1'b0;
         result_tag_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.pixel_valid) begin
                  z_re_q        <= bus.z0_real_in;
                  z_im_q        <= bus.z0_imag_in;
                  c_re_q        <= bus.c_real_in;
                  c_im_q        <= bus.c_imag_in;
                  // A zero budget still runs one iteration.
                  budget_q      <= (bus.cfg_max_iter == 8'd0) ? 8'd1 : bus.cfg_max_iter;
                  result_tag_q  <= bus.pixel_tag_in;
                  iter_q        <= '0;
                  pixel_ready_q <= 1'b0;
                  state_q       <= ITER;
               end
            end
            ITER: begin
`ifdef JULIA_ABORT_EN
               if (abort) begin
                  pixel_ready_q <= 1'b1;
                  state_q       <= IDLE;
               end else
`endif
               begin
                  z_re_q <= z_re_d;
                  z_im_q <= z_im_d;
                  iter_q <= iter_inc;
                  if (escape) begin
                     result_valid_q   <= 1'b1;
                     result_escaped_q <= 1'b1;
                     result_iter_q    <= iter_inc;
                     state_q          <= DONE;
                  end else if (iter_inc == budget_q) begin
                     result_valid_q   <= 1'b1;
                     result_escaped_q <= 1'b0;
                     result_iter_q    <= budget_q;
                     state_q          <= DONE;
                  end
               end
            end
            DONE: begin
`ifdef JULIA_ABORT_EN
               if (abort) begin
                  result_valid_q <= 1'b0;
                  pixel_ready_q  <= 1'b1;
                  state_q        <= IDLE;
               end else
`endif
               if (bus.result_ready) begin
                  result_valid_q <= 1'b0;
                  pixel_ready_q  <= 1'b1;
                  state_q        <= IDLE;
               end
            end
            default: begin
               result_valid_q <= 1'b0;
               pixel_ready_q  <= 1'b1;
               state_q        <= IDLE;
            end
         endcase
      end
   end

   assign bus.pixel_ready    = pixel_ready_q;
   assign bus.result_valid   = result_valid_q;
   assign bus.result_iter    = result_iter_q;
   assign bus.result_escaped = result_escaped_q;
   assign bus.result_tag     = result_tag_q;
endmodule

// File: tb/tb_julia_pixel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_julia_pixel_sequencer
// Directed self-checking bench for julia_pixel_sequencer. Covers reset state,
// escape, budget exhaustion, the 4.0 threshold boundary, zero budget, result
// hold under back-pressure, back-to-back ordering and mid-job reset
// (plus abort when JULIA_ABORT_EN is defined).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_julia_pixel_sequencer;
   logic clk;
   logic rst;
`ifdef JULIA_ABORT_EN
   logic abort;
`endif

   int errors = 0;
   int checks = 0;

   julia_pixel_sequencer_if #(.WIDTH(20), .TAG_W(16)) bus ();

   julia_pixel_sequencer #(.WIDTH(20), .FRACTIONAL(10), .TAG_W(16)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef JULIA_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one job on a falling edge; returns just after the accepting edge.
   task automatic send_job(input logic signed [19:0] zr, input logic signed [19:0] zi,
                           input logic signed [19:0] cr, input logic signed [19:0] ci,
                           input logic [7:0] mx, input logic [15:0] tg);
      @(negedge clk);
      bus.pixel_valid  = 1'b1;
      bus.z0_real_in   = zr;
      bus.z0_imag_in   = zi;
      bus.c_real_in    = cr;
      bus.c_imag_in    = ci;
      bus.cfg_max_iter = mx;
      bus.pixel_tag_in = tg;
      @(posedge clk);
      #1;
      bus.pixel_valid  = 1'b0;
   endtask

   // Count edges after acceptance until result_valid (bounded).
   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!bus.result_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      $display("job tag=%h iter=%0d escaped=%0d cycles=%0d",
               bus.result_tag, bus.result_iter, bus.result_escaped, cyc);
   endtask

   task automatic take_result();
      @(negedge clk);
      bus.result_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.result_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.pixel_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.pixel_ready); end
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid); end
      checks++; if (bus.result_iter !== 8'd0) begin errors++; $display("FAIL reset_iter: got %0d expected 0", bus.result_iter); end
      checks++; if (bus.result_escaped !== 1'b0) begin errors++; $display("FAIL reset_escaped: got %b expected 0", bus.result_escaped); end
      checks++; if (bus.result_tag !== 16'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0000", bus.result_tag); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // z0=1.0+0.5i, c=-0.5+0.5i: z1=0.25+1.5i (|z|^2=2.3125), z2=-2.6875+1.25i escapes.
   task automatic test_escape();
      int cyc;
      send_job(20'sd1024, 20'sd512, -20'sd512, 20'sd512, 8'd16, 16'h1111);
      wait_result(cyc);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL escape_latency: got %0d expected 2", cyc); end
      checks++; if (bus.result_iter !== 8'd2) begin errors++; $display("FAIL escape_iter: got %0d expected 2", bus.result_iter); end
      checks++; if (bus.result_escaped !== 1'b1) begin errors++; $display("FAIL escape_flag: got %b expected 1", bus.result_escaped); end
      checks++; if (bus.result_tag !== 16'h1111) begin errors++; $display("FAIL escape_tag: got %h expected 1111", bus.result_tag); end
      take_result();
   endtask

   // z0=0, c=0 never escapes: full budget of 16.
   task automatic test_budget();
      int cyc;
      send_job(20'sd0, 20'sd0, 20'sd0, 20'sd0, 8'd16, 16'h2222);
      wait_result(cyc);
      checks++; if (cyc !== 16) begin errors++; $display("FAIL budget_latency: got %0d expected 16", cyc); end
      checks++; if (bus.result_iter !== 8'd16) begin errors++; $display("FAIL budget_iter: got %0d expected 16", bus.result_iter); end
      checks++; if (bus.result_escaped !== 1'b0) begin errors++; $display("FAIL budget_flag: got %b expected 0", bus.result_escaped); end
      take_result();
   endtask

   // z0=0, c=2.0: z1=2.0 gives |z|^2 exactly 4.0 (no escape), z2=6.0 escapes.
   task automatic test_threshold();
      int cyc;
      send_job(20'sd0, 20'sd0, 20'sd2048, 20'sd0, 8'd255, 16'h3333);
      wait_result(cyc);
      checks++; if (bus.result_iter !== 8'd2) begin errors++; $display("FAIL thresh_iter: got %0d expected 2", bus.result_iter); end
      checks++; if (bus.result_escaped !== 1'b1) begin errors++; $display("FAIL thresh_flag: got %b expected 1", bus.result_escaped); end
      take_result();
   endtask

   task automatic test_zero_budget();
      int cyc;
      send_job(20'sd0, 20'sd0, 20'sd0, 20'sd0, 8'd0, 16'h4444);
      wait_result(cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", cyc); end
      checks++; if (bus.result_iter !== 8'd1) begin errors++; $display("FAIL zero_iter: got %0d expected 1", bus.result_iter); end
      checks++; if (bus.result_escaped !== 1'b0) begin errors++; $display("FAIL zero_flag: got %b expected 0", bus.result_escaped); end
      take_result();
   endtask

   task automatic test_hold_back_to_back();
      int cyc;
      logic [15:0] got_tags[$];
      send_job(20'sd0, 20'sd0, 20'sd0, 20'sd0, 8'd3, 16'hABCD);
      wait_result(cyc);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus.result_valid); end
         checks++; if (bus.result_iter !== 8'd3) begin errors++; $display("FAIL hold_iter[%0d]: got %0d expected 3", i, bus.result_iter); end
         checks++; if (bus.result_escaped !== 1'b0) begin errors++; $display("FAIL hold_flag[%0d]: got %b expected 0", i, bus.result_escaped); end
         checks++; if (bus.result_tag !== 16'hABCD) begin errors++; $display("FAIL hold_tag[%0d]: got %h expected abcd", i, bus.result_tag); end
         checks++; if (bus.pixel_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, bus.pixel_ready); end
      end
      take_result();
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", bus.result_valid); end
      checks++; if (bus.pixel_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", bus.pixel_ready); end

      send_job(20'sd1024, 20'sd512, -20'sd512, 20'sd512, 8'd16, 16'h0A01);
      wait_result(cyc);
      got_tags.push_back(bus.result_tag);
      take_result();
      send_job(20'sd0, 20'sd0, 20'sd0, 20'sd0, 8'd4, 16'h0B02);
      wait_result(cyc);
      checks++; if (bus.result_iter !== 8'd4) begin errors++; $display("FAIL b2b_iter: got %0d expected 4", bus.result_iter); end
      got_tags.push_back(bus.result_tag);
      take_result();
      checks++; if (got_tags.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_tags.size()); end
      else begin
         checks++; if (got_tags[0] !== 16'h0A01) begin errors++; $display("FAIL b2b_tag0: got %h expected 0a01", got_tags[0]); end
         checks++; if (got_tags[1] !== 16'h0B02) begin errors++; $display("FAIL b2b_tag1: got %h expected 0b02", got_tags[1]); end
      end
   endtask

   task automatic test_reset_midjob();
      int cyc;
      int vcnt;
      send_job(20'sd0, 20'sd0, 20'sd0, 20'sd0, 8'd200, 16'h5555);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.pixel_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.pixel_ready); end
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.result_valid); end
      @(negedge clk);
      rst = 1'b0;
      vcnt = 0;
      repeat (210) begin
         @(posedge clk);
         #1;
         if (bus.result_valid) vcnt++;
      end
      checks++; if (vcnt !== 0) begin errors++; $display("FAIL midrst_no_result: got %0d valid cycles expected 0", vcnt); end
      send_job(20'sd1024, 20'sd512, -20'sd512, 20'sd512, 8'd16, 16'h6666);
      wait_result(cyc);
      checks++; if (bus.result_iter !== 8'd2) begin errors++; $display("FAIL midrst_after_iter: got %0d expected 2", bus.result_iter); end
      checks++; if (bus.result_tag !== 16'h6666) begin errors++; $display("FAIL midrst_after_tag: got %h expected 6666", bus.result_tag); end
      take_result();
   endtask

`ifdef JULIA_ABORT_EN
   task automatic test_abort();
      int cyc;
      int vcnt;
      // abort while idle is ignored: the job is still accepted
      abort = 1'b1;
      send_job(20'sd0, 20'sd0, 20'sd0, 20'sd0, 8'd200, 16'h7777);
      abort = 1'b0;
      checks++; if (bus.pixel_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ignored: got ready %b expected 0", bus.pixel_ready); end
      @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checks++; if (bus.pixel_ready !== 1'b1) begin errors++; $display("FAIL abort_iter_ready: got %b expected 1", bus.pixel_ready); end
      vcnt = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.result_valid) vcnt++;
      end
      checks++; if (vcnt !== 0) begin errors++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", vcnt); end
      // abort while a result is waiting discards it
      send_job(20'sd0, 20'sd0, 20'sd0, 20'sd0, 8'd1, 16'h8888);
      wait_result(cyc);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL abort_done_valid: got %b expected 0", bus.result_valid); end
      checks++; if (bus.pixel_ready !== 1'b1) begin errors++; $display("FAIL abort_done_ready: got %b expected 1", bus.pixel_ready); end
      send_job(20'sd0, 20'sd0, 20'sd2048, 20'sd0, 8'd255, 16'h9999);
      wait_result(cyc);
      checks++; if (bus.result_iter !== 8'd2) begin errors++; $display("FAIL abort_after_iter: got %0d expected 2", bus.result_iter); end
      take_result();
   endtask
`endif

   initial begin
      rst                = 1'b1;
      bus.pixel_valid    = 1'b0;
      bus.z0_real_in     = '0;
      bus.z0_imag_in     = '0;
      bus.c_real_in      = '0;
      bus.c_imag_in      = '0;
      bus.cfg_max_iter   = '0;
      bus.pixel_tag_in   = '0;
      bus.result_ready   = 1'b0;
`ifdef JULIA_ABORT_EN
      abort              = 1'b0;
`endif
      test_reset();
      test_escape();
      test_budget();
      test_threshold();
      test_zero_budget();
      test_hold_back_to_back();
      test_reset_midjob();
`ifdef JULIA_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
